// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices and the lock FSM encoding.
package dmem_pkg;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-request round-robin picker; a forced owner overrides the round-robin choice.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_port,
  output logic [1:0] gnt
);

  // Forced owner first, otherwise the port that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (force_en) begin
      gnt = force_port ? 2'b10 : 2'b01;
    end else begin
      case (req)
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the loader (port 1)
// with round-robin arbitration, a bounded burst lock and one-cycle read return.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATA_BITS-1:0] rdata0,
  output logic [DATA_BITS-1:0] rdata1,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam int CNT_BITS = $clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(MAX_BURST);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

  arb_state_e          state_r, state_nxt_s;
  logic                last_r, last_nxt_s;
  logic                owner_r, owner_nxt_s;
  logic [CNT_BITS-1:0] burst_cnt_r, burst_cnt_nxt_s;
  logic [1:0]          rd_pend_r;

  logic [1:0] req_s, gnt_s;
  logic       force_en_s, any_s, win_s, win_lock_s, win_we_s, other_req_s;

  assign req_s      = {req1, req0};
  assign force_en_s = (state_r == LOCKED) && req_s[owner_r] && (burst_cnt_r < CNT_MAX);

  rr_pick2 u_pick (
    .req        (req_s),
    .last       (last_r),
    .force_en   (force_en_s),
    .force_port (owner_r),
    .gnt        (gnt_s)
  );

  assign any_s       = |gnt_s;
  assign win_s       = gnt_s[1];
  assign win_lock_s  = win_s ? lock1 : lock0;
  assign win_we_s    = win_s ? we1 : we0;
  assign other_req_s = win_s ? req0 : req1;

  assign gnt0    = gnt_s[0];
  assign gnt1    = gnt_s[1];
  assign rvalid0 = rd_pend_r[0];
  assign rvalid1 = rd_pend_r[1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  // State register: lock FSM, round-robin pointer, burst counter and pending-read flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FREE;
      last_r      <= PORT_LOADER;
      owner_r     <= PORT_CORE;
      burst_cnt_r <= CNT_ZERO;
      rd_pend_r   <= 2'b00;
    end else begin
      state_r     <= state_nxt_s;
      last_r      <= last_nxt_s;
      owner_r     <= owner_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
      rd_pend_r   <= {gnt_s[1] & ~we1, gnt_s[0] & ~we0};
    end
  end

  // Next state: a locking winner (re)takes the lock, anything else drops back to FREE.
  always_comb begin
    state_nxt_s     = state_r;
    last_nxt_s      = last_r;
    owner_nxt_s     = owner_r;
    burst_cnt_nxt_s = burst_cnt_r;
    if (any_s) begin
      last_nxt_s = win_s;
      if (win_lock_s) begin
        state_nxt_s = LOCKED;
        owner_nxt_s = win_s;
        // Only contended grants count toward the cap, so an idle rival never forces a switch.
        if ((state_r == LOCKED) && (owner_r == win_s) && other_req_s) begin
          burst_cnt_nxt_s = burst_cnt_r + CNT_ONE;
        end else begin
          burst_cnt_nxt_s = CNT_ONE;
        end
      end else begin
        state_nxt_s     = FREE;
        burst_cnt_nxt_s = CNT_ZERO;
      end
    end else begin
      state_nxt_s     = FREE;
      burst_cnt_nxt_s = CNT_ZERO;
    end
  end

  // Outputs: steer the winner onto the memory port, all zero when nobody wins.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = {ADDR_BITS{1'b0}};
    mem_wdata = {DATA_BITS{1'b0}};
    if (any_s) begin
      mem_we    = win_we_s;
      mem_re    = ~win_we_s;
      mem_addr  = win_s ? addr1 : addr0;
      mem_wdata = win_s ? wdata1 : wdata0;
    end else begin
      mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration model and a shadow memory.
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [5:0]  addr0 = 6'd0, addr1 = 6'd0;
  logic [63:0] wdata0 = 64'd0, wdata1 = 64'd0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_re;
  logic [63:0] rdata0, rdata1, mem_wdata;
  logic [63:0] mem_rdata = 64'd0;
  logic [5:0]  mem_addr;

  logic [63:0] mem [64];
  logic [63:0] ref_mem [64];

  int total = 0;
  int bad = 0;

  // model state
  int          m_last, m_owner, m_streak, m_win;
  bit          m_locked, m_rv0, m_rv1;
  logic [63:0] m_rd;
  // expected combinational outputs for the current cycle
  logic [3:0]  e_ctl;
  logic [5:0]  e_addr;
  logic [63:0] e_wdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_BITS(6), .DATA_BITS(64), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // single-port memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic model_reset();
    m_last = 1; m_owner = 0; m_streak = 0; m_locked = 0; m_rv0 = 0; m_rv1 = 0;
  endtask

  // Apply inputs, move to the sampling edge and compute what this cycle should show.
  task automatic drive(input logic r0, w0, l0, input logic [5:0] a0, input logic [63:0] d0,
                       input logic r1, w1, l1, input logic [5:0] a1, input logic [63:0] d1);
    bit rq [2];
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    rq[0] = r0; rq[1] = r1;
    if (m_locked && rq[m_owner] && m_streak < MAXB) m_win = m_owner;
    else if (r0 && r1) m_win = 1 - m_last;
    else if (r0) m_win = 0;
    else if (r1) m_win = 1;
    else m_win = -1;
    e_addr = 6'd0; e_wdata = 64'd0; e_ctl = 4'b0000;
    if (m_win == 0) begin
      e_ctl = {1'b0, 1'b1, w0, ~w0}; e_addr = a0; e_wdata = d0;
    end else if (m_win == 1) begin
      e_ctl = {1'b1, 1'b0, w1, ~w1}; e_addr = a1; e_wdata = d1;
    end
  endtask

  // Advance the model across the rising edge.
  task automatic commit();
    bit w, l, other;
    int a;
    m_rv0 = 0; m_rv1 = 0;
    if (m_win >= 0) begin
      w = (m_win == 0) ? we0 : we1;
      l = (m_win == 0) ? lock0 : lock1;
      a = (m_win == 0) ? int'(addr0) : int'(addr1);
      other = (m_win == 0) ? req1 : req0;
      if (w) ref_mem[a] = (m_win == 0) ? wdata0 : wdata1;
      else begin
        m_rd = ref_mem[a];
        if (m_win == 0) m_rv0 = 1; else m_rv1 = 1;
      end
      if (l) begin
        m_streak = (m_locked && m_owner == m_win && other) ? m_streak + 1 : 1;
        m_locked = 1; m_owner = m_win;
      end else begin
        m_locked = 0; m_streak = 0;
      end
      m_last = m_win;
    end else begin
      m_locked = 0; m_streak = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
    total++;
    if ({gnt1, gnt0, mem_we, mem_re, rvalid1, rvalid0} !== 6'b000000) begin
      bad++; $display("FAIL reset_ctl got=%b want=000000", {gnt1, gnt0, mem_we, mem_re, rvalid1, rvalid0});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 70'd0) begin
      bad++; $display("FAIL reset_bus got addr=%0d wdata=%h want 0", mem_addr, mem_wdata);
    end
    commit();
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b0, 1'b0, 6'd5, 64'd0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
    total++;
    if ({gnt1, gnt0, mem_we, mem_re, mem_addr} !== {4'b0101, 6'd5}) begin
      bad++; $display("FAIL single_grant got=%b addr=%0d want ctl=0101 addr=5", {gnt1, gnt0, mem_we, mem_re}, mem_addr);
    end
    commit();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
    total++;
    if ({rvalid1, rvalid0} !== 2'b01 || rdata0 !== ref_mem[5]) begin
      bad++; $display("FAIL single_rdata got rv=%b data=%h want rv=01 data=%h", {rvalid1, rvalid0}, rdata0, ref_mem[5]);
    end
    commit();
  endtask

  task automatic test_alternate();
    logic [1:0] prev = 2'b00;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 6'($urandom), 64'd0, 1'b1, 1'b0, 1'b0, 6'($urandom), 64'd0);
      total++;
      if ({gnt1, gnt0, mem_we, mem_re} !== e_ctl || mem_addr !== e_addr) begin
        bad++; $display("FAIL alt_grant cyc=%0d got=%b/%0d want=%b/%0d", i, {gnt1, gnt0, mem_we, mem_re}, mem_addr, e_ctl, e_addr);
      end
      total++;
      if (i > 0 && ({gnt1, gnt0} !== ~prev || {rvalid1, rvalid0} !== prev)) begin
        bad++; $display("FAIL alt_pattern cyc=%0d gnt=%b rv=%b prev_gnt=%b", i, {gnt1, gnt0}, {rvalid1, rvalid0}, prev);
      end
      total++;
      if (m_rv0 && rdata0 !== m_rd || m_rv1 && rdata1 !== m_rd) begin
        bad++; $display("FAIL alt_rdata cyc=%0d got=%h/%h want=%h", i, rdata0, rdata1, m_rd);
      end
      prev = {gnt1, gnt0};
      commit();
    end
  endtask

  task automatic test_burst();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 6'd1, 64'd0, 1'b1, 1'b0, 1'b1, 6'd2, 64'd0);
      total++;
      if (gnt1 !== ((i % 5) != 0) || {gnt1, gnt0, mem_we, mem_re} !== e_ctl) begin
        bad++; $display("FAIL burst cyc=%0d got gnt=%b want gnt1=%0d ctl=%b", i, {gnt1, gnt0}, (i % 5) != 0, e_ctl);
      end
      commit();
    end
  endtask

  task automatic test_uncontended_lock();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 1'b1, 6'd7, 64'(i));
      total++;
      if ({gnt1, gnt0, mem_we, mem_re} !== 4'b1010 || mem_wdata !== 64'(i)) begin
        bad++; $display("FAIL lock_solo cyc=%0d got=%b wdata=%0d want=1010 wdata=%0d", i, {gnt1, gnt0, mem_we, mem_re}, mem_wdata, i);
      end
      commit();
    end
  endtask

  task automatic test_write_then_read();
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 6'd3, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 6'd3, 64'd0);
    total++;
    if ({gnt1, gnt0, mem_we, mem_re} !== 4'b0110 || mem_wdata !== 64'hDEAD_BEEF) begin
      bad++; $display("FAIL wr_first got=%b wdata=%h want=0110 wdata=deadbeef", {gnt1, gnt0, mem_we, mem_re}, mem_wdata);
    end
    commit();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 6'd3, 64'd0);
    total++;
    if ({gnt1, gnt0, mem_we, mem_re} !== 4'b1001) begin
      bad++; $display("FAIL rd_second got=%b want=1001", {gnt1, gnt0, mem_we, mem_re});
    end
    commit();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 64'hDEAD_BEEF) begin
      bad++; $display("FAIL rd_after_wr got rv=%b data=%h want rv=1 data=deadbeef", rvalid1, rdata1);
    end
    commit();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 1'b0, 6'd9, 64'd0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
    total++;
    if (gnt0 !== 1'b1) begin
      bad++; $display("FAIL rst_mid_gnt got=%b want=1", gnt0);
    end
    commit();
    req0 = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 6'd4, 64'd0, 1'b1, 1'b0, 1'b0, 6'd8, 64'd0);
    total++;
    if ({rvalid1, rvalid0} !== 2'b00 || {gnt1, gnt0} !== 2'b01) begin
      bad++; $display("FAIL rst_mid rv=%b gnt=%b want rv=00 gnt=01", {rvalid1, rvalid0}, {gnt1, gnt0});
    end
    commit();
  endtask

  task automatic test_random();
    logic r [2], w [2], l [2];
    logic [5:0] a [2];
    logic [63:0] d [2];
    for (int p = 0; p < 2; p++) begin
      r[p] = 1'b0; w[p] = 1'b0; l[p] = 1'b0; a[p] = 6'd0; d[p] = 64'd0;
    end
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < 2; p++) begin
        l[p] = ($urandom_range(0, 2) != 0);
        if (!r[p]) begin
          r[p] = ($urandom_range(0, 3) != 0);
          w[p] = $urandom_range(0, 1);
          a[p] = 6'($urandom_range(0, 15));
          d[p] = {$urandom, $urandom};
        end
      end
      drive(r[0], w[0], l[0], a[0], d[0], r[1], w[1], l[1], a[1], d[1]);
      total++;
      if ({gnt1, gnt0, mem_we, mem_re} !== e_ctl || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        bad++; $display("FAIL rand_bus cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", i, {gnt1, gnt0, mem_we, mem_re}, mem_addr, mem_wdata, e_ctl, e_addr, e_wdata);
      end
      total++;
      if ({rvalid1, rvalid0} !== {m_rv1, m_rv0} || (m_rv0 && rdata0 !== m_rd) || (m_rv1 && rdata1 !== m_rd)) begin
        bad++; $display("FAIL rand_read cyc=%0d rv=%b data=%h want rv=%b data=%h", i, {rvalid1, rvalid0}, mem_rdata, {m_rv1, m_rv0}, m_rd);
      end
      if (m_win >= 0) r[m_win] = ($urandom_range(0, 1) != 0);
      commit();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    model_reset();
    test_reset();
    test_single_read();
    test_alternate();
    test_burst();
    test_uncontended_lock();
    test_write_then_read();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the processor core (port 0) and a loader/debug requester (port 1). It sits between the core's data-memory port and the data memory. Each cycle it grants at most one access, using round-robin priority and a bounded burst lock. It returns read data to the winning port after the memory's fixed one-cycle read latency.

## Interface
- `ADDR_BITS`, 6, data-memory word address width (matches `d_addr_bits`)
- `DATA_BITS`, 64, data word width
- `MAX_BURST`, 4, maximum consecutive grants to one locked port while the other port is requesting (≥1)

- `clk`  in  1  single system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`/`req1`  in  1  access request, held until granted
- `we0`/`we1`  in  1  1 = write, 0 = read; valid with req
- `lock0`/`lock1`  in  1  requester wants to keep the grant (burst); sampled only while granted
- `addr0`/`addr1`  in  ADDR_BITS  word address
- `wdata0`/`wdata1`  in  DATA_BITS  write data
- `gnt0`/`gnt1`  out  1  access issued this cycle (combinational)
- `rvalid0`/`rvalid1`  out  1  read data valid for that port (registered)
- `rdata0`/`rdata1`  out  DATA_BITS  read data, both driven from `mem_rdata`
- `mem_we`  out  1  memory write enable
- `mem_re`  out  1  memory read enable
- `mem_addr`  out  ADDR_BITS  memory address
- `mem_wdata`  out  DATA_BITS  memory write data
- `mem_rdata`  in  DATA_BITS  memory read data, valid one cycle after the `mem_re` cycle

## Operation
- State: `last` (1 bit, port most recently granted), `owner` (1 bit), `burst_cnt` (clog2(MAX_BURST+1) bits), `rd_pend` (2 bits, one per port).
- FSM states:
  - FREE: no lock held.
  - LOCKED: owner holds the lock.
- Arbitration in FREE:
  - Only one port requests: that port wins.
  - Both ports request: the port ≠ `last` wins.
- Arbitration in LOCKED:
  - Owner requesting and `burst_cnt` < MAX_BURST: owner wins.
  - Otherwise: fall back to the FREE rule.
- Grant effects:
  - Winner's `gnt` = 1 and the other port's `gnt` = 0.
  - `mem_addr`/`mem_wdata` = winner's signals; `mem_we` = winner's `we`; `mem_re` = ~winner's `we`.
  - No winner: `mem_we` = `mem_re` = 0 and `mem_addr`/`mem_wdata` = 0.
- Update on a grant: `last` ← winner.
  - Winner asserted lock: go to LOCKED, `owner` ← winner.
  - Winner is the same as the previous owner and the other port is requesting: `burst_cnt` increments.
  - Otherwise: `burst_cnt` ← 1.
- Lock release → FREE, `burst_cnt` ← 0. Any of these releases the lock:
  - Owner granted with lock = 0.
  - Owner not requesting.
  - Burst cap forced a switch to the other port.
- Burst counting: `burst_cnt` does not increment while the other port is idle, so the owner keeps the lock without limit when uncontended.
- Read return: `rd_pend[p]` ← (`gnt_p` & ~`we_p`) every cycle; `rvalid_p` = `rd_pend[p]`.
- Writes produce no response; `gnt` is the completion.

## Timing
- Reset values: `last` = 1 (so port 0 wins first), `owner` = 0, `burst_cnt` = 0, FSM = FREE, `rd_pend` = 0, hence `rvalid0` = `rvalid1` = 0.
  - All combinational outputs are 0 while no request is active.
- Grant latency: 0 cycles; `gnt` is asserted in the cycle of the request when that port wins.
- Read latency: `rvalid` and `rdata` appear exactly 1 cycle after the granting cycle.
- Throughput: one access per cycle. Back-to-back reads to alternating ports return in order, one per cycle.
- Requester rules:
  - Must hold `req`/`we`/`addr`/`wdata` stable until it sees `gnt`.
  - May drop or change `req` in the cycle after `gnt`.
- Simultaneous first requests after reset: port 0 wins.
- Reset asserted mid-read: the pending `rvalid` is suppressed (forced 0 in the next cycle). Any memory write already issued in that cycle completes at the memory.
- `lock` on a losing port is ignored.
- `MAX_BURST` = 1 degenerates to pure round-robin.

## Structure
- Shared package `dmem_pkg`:
  - Port index constants `PORT_CORE` = 0 and `PORT_LOADER` = 1.
  - FSM state enum {FREE, LOCKED}.
- One natural sub-module: `rr_pick2`, a combinational two-request round-robin picker. Inputs: req vector, `last`, forced owner. Outputs: grant vector.
- Everything else lives in the top module. No memories inside.

## Test plan
- After reset, `req0` = 1 with read at `addr0` = 5 → `gnt0` = 1 the same cycle, `mem_re` = 1, `mem_addr` = 5. Next cycle `rvalid0` = 1 and `rdata0` = memory[5].
- `req0` and `req1` held every cycle, no lock → grants alternate 0, 1, 0, 1. `rvalid` follows the grant pattern one cycle later.
- `req1` held with `lock1` = 1 and `req0` held, `MAX_BURST` = 4 → port 1 granted 4 consecutive cycles, then port 0 once, then port 1 re-locks.
- Only `req1` with `lock1` held for 10 cycles → `gnt1` stays 1 for all 10 cycles. `burst_cnt` stays at 1 and no forced switch occurs.
- Port 0 writes 0xDEAD_BEEF to `addr0` = 3 while port 1 reads `addr1` = 3 in the same cycle → port 0 wins (reset priority). Port 1 is granted next cycle and receives 0xDEAD_BEEF.
- `rst` asserted in the cycle after a port 0 read grant → `rvalid0` = 0 the next cycle. After release, the first simultaneous request goes to port 0.
